// File: rtl/uart_rx_fifo_ctrl.sv
// rtl/uart_rx_fifo_ctrl.sv - UART receive FIFO with line status and RDA/RLS/timeout interrupts
module uart_rx_fifo_ctrl #(
    parameter int DEPTH    = 16,
    parameter int TO_TICKS = 640
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     baud_pulse,
    input  logic                     rx_push,
    input  logic [7:0]               rx_data,
    input  logic                     rx_pe,
    input  logic                     rx_fe,
    input  logic                     rx_bi,
    input  logic                     fifo_en,
    input  logic                     fifo_clr,
    input  logic [1:0]               trig_lvl,
    input  logic                     rd_en,
    input  logic                     lsr_rd,
    output logic [7:0]               rd_data,
    output logic                     dr,
    output logic                     oe,
    output logic                     pe_o,
    output logic                     fe_o,
    output logic                     bi_o,
    output logic                     fifo_err,
    output logic [$clog2(DEPTH):0]   rx_level,
    output logic                     irq_rls,
    output logic                     irq_rda,
    output logic                     irq_to
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(TO_TICKS + 1);

    logic [10:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [LW-1:0]  level, err_cnt, trig_thr;
    logic [TW-1:0]  to_cnt;
    logic           fifo_en_q;

    logic [10:0]    head, new_entry;
    logic           empty, full, flush, head_err, new_err;
    logic           do_push, do_pop, ovr, hold_ovw;

    assign empty     = (level == '0);
    assign full      = fifo_en ? (level == LW'(DEPTH)) : !empty;
    assign flush     = fifo_clr | (fifo_en ^ fifo_en_q);
    assign head      = mem[rd_ptr];
    assign new_entry = {rx_bi, rx_fe, rx_pe, rx_data};
    assign head_err  = !empty & (|head[10:8]);
    assign new_err   = |new_entry[10:8];

    // Pop is resolved before push, so a full FIFO can accept a push in the popping cycle.
    assign do_pop    = rd_en & !empty & !flush;
    assign do_push   = rx_push & !flush & (!full | do_pop);
    assign ovr       = rx_push & !flush & full & !do_pop;
    assign hold_ovw  = ovr & !fifo_en;

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= new_entry;
        else if (hold_ovw)
            mem[rd_ptr] <= new_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            err_cnt   <= '0;
            to_cnt    <= '0;
            oe        <= 1'b0;
            irq_to    <= 1'b0;
            fifo_en_q <= 1'b0;
        end else begin
            fifo_en_q <= fifo_en;

            if (ovr)
                oe <= 1'b1;
            else if (lsr_rd)
                oe <= 1'b0;

            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                level   <= '0;
                err_cnt <= '0;
            end else begin
                if (do_push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)
                    rd_ptr <= rd_ptr + 1'b1;
                level   <= level + LW'(do_push) - LW'(do_pop);
                // A holding-register overwrite swaps the old entry's flags for the new one's.
                err_cnt <= err_cnt + LW'(do_push & new_err) + LW'(hold_ovw & new_err)
                                   - LW'(do_pop & head_err) - LW'(hold_ovw & head_err);
            end

            if (flush | !fifo_en | rx_push | do_pop | empty) begin
                to_cnt <= '0;
                irq_to <= 1'b0;
            end else if (baud_pulse && (to_cnt != TW'(TO_TICKS))) begin
                to_cnt <= to_cnt + 1'b1;
                if (to_cnt == TW'(TO_TICKS - 1))
                    irq_to <= 1'b1;
            end
        end
    end

    always_comb begin
        trig_thr = LW'(1);
        case (trig_lvl)
            2'b00: trig_thr = LW'(1);
            2'b01: trig_thr = LW'(4);
            2'b10: trig_thr = LW'(8);
            2'b11: trig_thr = LW'(14);
            default: trig_thr = LW'(1);
        endcase
    end

    assign rd_data  = empty ? 8'h00 : head[7:0];
    assign pe_o     = !empty & head[8];
    assign fe_o     = !empty & head[9];
    assign bi_o     = !empty & head[10];
    assign dr       = !empty;
    assign fifo_err = (err_cnt != '0);
    assign rx_level = level;
    assign irq_rls  = oe | pe_o | fe_o | bi_o;
    assign irq_rda  = fifo_en ? (level >= trig_thr) : dr;

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// tb/tb_uart_rx_fifo_ctrl.sv - directed self-checking bench for uart_rx_fifo_ctrl
module tb_uart_rx_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_pulse = 1'b0;
    logic       rx_push = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_pe = 1'b0, rx_fe = 1'b0, rx_bi = 1'b0;
    logic       fifo_en = 1'b1;
    logic       fifo_clr = 1'b0;
    logic [1:0] trig_lvl = 2'b01;
    logic       rd_en = 1'b0;
    logic       lsr_rd = 1'b0;
    logic [7:0] rd_data;
    logic       dr, oe, pe_o, fe_o, bi_o, fifo_err, irq_rls, irq_rda, irq_to;
    logic [4:0] rx_level;

    int pass_cnt = 0;
    int total_cnt = 0;

    uart_rx_fifo_ctrl #(.DEPTH(16), .TO_TICKS(640)) dut (
        .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .rx_push(rx_push),
        .rx_data(rx_data), .rx_pe(rx_pe), .rx_fe(rx_fe), .rx_bi(rx_bi),
        .fifo_en(fifo_en), .fifo_clr(fifo_clr), .trig_lvl(trig_lvl),
        .rd_en(rd_en), .lsr_rd(lsr_rd), .rd_data(rd_data), .dr(dr), .oe(oe),
        .pe_o(pe_o), .fe_o(fe_o), .bi_o(bi_o), .fifo_err(fifo_err),
        .rx_level(rx_level), .irq_rls(irq_rls), .irq_rda(irq_rda), .irq_to(irq_to)
    );

    always #5 clk = ~clk;

    logic [21:0] all_outs;
    assign all_outs = {rd_data, dr, oe, pe_o, fe_o, bi_o, fifo_err, rx_level, irq_rls, irq_rda, irq_to};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic fe);
        rx_push = 1'b1; rx_data = d; rx_fe = fe;
        tick();
        rx_push = 1'b0; rx_fe = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        total_cnt++;
        if (all_outs !== 22'h0) $display("FAIL reset_outputs got %h want 000000", all_outs);
        else pass_cnt++;
        rst = 1'b0;
        tick(); tick();
        total_cnt++;
        if (all_outs !== 22'h0) $display("FAIL post_reset_outputs got %h want 000000", all_outs);
        else pass_cnt++;
    endtask

    task automatic test_rda();
        trig_lvl = 2'b01;
        for (int i = 0; i < 3; i++) push(8'h41 + 8'(i), 1'b0);
        total_cnt++;
        if (irq_rda !== 1'b0) $display("FAIL rda_below_trig got %b want 0", irq_rda);
        else pass_cnt++;
        push(8'h44, 1'b0);
        total_cnt++;
        if (irq_rda !== 1'b1) $display("FAIL rda_at_trig got %b want 1", irq_rda);
        else pass_cnt++;
        total_cnt++;
        if (rx_level !== 5'd4) $display("FAIL rda_level got %0d want 4", rx_level);
        else pass_cnt++;
        total_cnt++;
        if (rd_data !== 8'h41) $display("FAIL rda_head got %h want 41", rd_data);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) pop();
        total_cnt++;
        if ({dr, irq_rda} !== 2'b00) $display("FAIL rda_drained got %b want 00", {dr, irq_rda});
        else pass_cnt++;
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 17; i++) push(8'h60 + 8'(i), 1'b0);
        total_cnt++;
        if (oe !== 1'b1) $display("FAIL ovr_oe got %b want 1", oe);
        else pass_cnt++;
        total_cnt++;
        if (rx_level !== 5'd16) $display("FAIL ovr_level got %0d want 16", rx_level);
        else pass_cnt++;
        lsr_rd = 1'b1; tick(); lsr_rd = 1'b0;
        total_cnt++;
        if (oe !== 1'b0) $display("FAIL ovr_lsr_clear got %b want 0", oe);
        else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            total_cnt++;
            if (rd_data !== 8'h60 + 8'(i)) $display("FAIL ovr_order[%0d] got %h want %h", i, rd_data, 8'h60 + 8'(i));
            else pass_cnt++;
            pop();
        end
        total_cnt++;
        if (rx_level !== 5'd0) $display("FAIL ovr_empty got %0d want 0", rx_level);
        else pass_cnt++;
    endtask

    task automatic test_err_flags();
        push(8'h10, 1'b0);
        push(8'h55, 1'b1);
        total_cnt++;
        if ({fifo_err, fe_o, irq_rls} !== 3'b100) $display("FAIL err_behind got %b want 100", {fifo_err, fe_o, irq_rls});
        else pass_cnt++;
        pop();
        total_cnt++;
        if ({rd_data, fe_o, irq_rls, fifo_err} !== {8'h55, 3'b111}) $display("FAIL err_head got %h want %h", {rd_data, fe_o, irq_rls, fifo_err}, {8'h55, 3'b111});
        else pass_cnt++;
        pop();
        total_cnt++;
        if ({fifo_err, irq_rls} !== 2'b00) $display("FAIL err_cleared got %b want 00", {fifo_err, irq_rls});
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        push(8'h77, 1'b0);
        for (int i = 1; i <= 640; i++) begin
            baud_pulse = 1'b1; tick(); baud_pulse = 1'b0; tick();
            if (i == 639) begin
                total_cnt++;
                if (irq_to !== 1'b0) $display("FAIL to_early got %b want 0", irq_to);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (irq_to !== 1'b1) $display("FAIL to_fire got %b want 1", irq_to);
        else pass_cnt++;
        pop();
        total_cnt++;
        if ({irq_to, rx_level} !== 6'd0) $display("FAIL to_clear got %b want 000000", {irq_to, rx_level});
        else pass_cnt++;
    endtask

    task automatic test_hold_mode();
        fifo_en = 1'b0;
        tick();
        push(8'hA1, 1'b0);
        push(8'hA2, 1'b0);
        total_cnt++;
        if ({rd_data, oe, rx_level, irq_rda} !== {8'hA2, 1'b1, 5'd1, 1'b1}) $display("FAIL hold_ovw got %h want %h", {rd_data, oe, rx_level, irq_rda}, {8'hA2, 1'b1, 5'd1, 1'b1});
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            baud_pulse = 1'b1; tick(); baud_pulse = 1'b0;
        end
        total_cnt++;
        if (irq_to !== 1'b0) $display("FAIL hold_no_to got %b want 0", irq_to);
        else pass_cnt++;
        fifo_en = 1'b1;
        tick();
        total_cnt++;
        if ({rx_level, oe} !== {5'd0, 1'b1}) $display("FAIL hold_toggle_flush got %b want 000001", {rx_level, oe});
        else pass_cnt++;
        lsr_rd = 1'b1; tick(); lsr_rd = 1'b0;
        push(8'h01, 1'b0);
        push(8'h02, 1'b0);
        fifo_clr = 1'b1; rx_push = 1'b1; rx_data = 8'h03;
        tick();
        fifo_clr = 1'b0; rx_push = 1'b0;
        total_cnt++;
        if ({rx_level, oe, dr} !== 7'd0) $display("FAIL clr_flush got %b want 0000000", {rx_level, oe, dr});
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) push(8'h80 + 8'(i), 1'b0);
        rx_push = 1'b1; rx_data = 8'h99; rd_en = 1'b1;
        tick();
        rx_push = 1'b0; rd_en = 1'b0;
        total_cnt++;
        if ({oe, rx_level, rd_data} !== {1'b0, 5'd16, 8'h81}) $display("FAIL b2b_full got %h want %h", {oe, rx_level, rd_data}, {1'b0, 5'd16, 8'h81});
        else pass_cnt++;
        for (int i = 0; i < 15; i++) pop();
        total_cnt++;
        if (rd_data !== 8'h99) $display("FAIL b2b_tail got %h want 99", rd_data);
        else pass_cnt++;
        rx_push = 1'b1; rx_data = 8'h5A;
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (all_outs !== 22'h0) $display("FAIL mid_reset got %h want 000000", all_outs);
        else pass_cnt++;
        rx_push = 1'b0;
        tick();
        rst = 1'b0;
        tick(); tick();
        total_cnt++;
        if (all_outs !== 22'h0) $display("FAIL after_reset got %h want 000000", all_outs);
        else pass_cnt++;
    endtask

    initial begin
        #23;
        test_reset();
        test_rda();
        test_overrun();
        test_err_flags();
        test_timeout();
        test_hold_mode();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
